sram_pipelined: RTL
===================

# sram_pipelined

Parametrised single-clock dual-port (1 write, 1 read) on-chip buffer. It is the next-generation replacement for the accelerator's flat activation/weight SRAM. It adds:
- per-byte write enables,
- a configurable read-latency pipeline with a matching valid strobe,
- a hardware clear sequencer that zeroes the whole array.

It sits between the DMA/loader and the PE-array feeders.

## Interface
Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 64, word width; must be a multiple of 8. NBYTES = DATA_WIDTH/8.
- READ_LATENCY, 1, clock edges from read request to valid data; legal range 1..4.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_nrst  in  1  reset; asynchronous, active-low.
- i_write_en  in  1  write request.
- i_write_addr  in  ADDR_WIDTH  write address.
- i_data_in  in  DATA_WIDTH  write data.
- i_byte_en  in  NBYTES  per-byte write mask; bit k covers data[8k+7:8k].
- i_read_en  in  1  read request.
- i_read_addr  in  ADDR_WIDTH  read address.
- i_clear  in  1  one-cycle pulse; starts the array clear.
- o_data_out  out  DATA_WIDTH  read data; holds the last valid value.
- o_data_out_valid  out  1  one-cycle strobe per accepted read.
- o_busy  out  1  high while the clear is in progress.

## Operation
- FSM states:
  - IDLE: normal access.
  - CLEAR: internal counter clr_addr walks 0..DEPTH-1 and writes all-zero words (all bytes).
- Transitions:
  - IDLE→CLEAR when i_clear=1. clr_addr loads 0.
  - CLEAR→IDLE on the edge that writes DEPTH-1. o_busy falls on that same edge.
  - i_clear while in CLEAR is ignored; no restart.
- In CLEAR, external i_write_en and i_read_en are dropped. No array write occurs, and no valid is issued for them. Reads already in the pipeline complete normally.
- Write in IDLE: for each k with i_byte_en[k]=1, byte k of mem[i_write_addr] is updated. Other bytes are untouched. i_byte_en=0 means no change.
- Read in IDLE: the array is sampled at mem[i_read_addr] on the request edge. The result travels through READ_LATENCY-1 further register stages. A valid bit travels alongside it.
- o_data_out updates only when the valid bit reaches the output. Otherwise it holds its value.
- Back-to-back reads are supported every cycle; throughput is 1 word/clk.
- Simultaneous read and write to different addresses are independent.
- Same-address read and write in the same cycle depends on CONFIGURATION (see below).
- The array itself is not reset. Contents after reset are undefined until written or cleared.

## Timing
- Reset values: o_data_out=0, o_data_out_valid=0, o_busy=0. FSM=IDLE, clr_addr=0, all pipeline valid bits cleared.
- Read latency: request sampled at edge N gives o_data_out_valid=1 and data after edge N+READ_LATENCY-1. With READ_LATENCY=1 this is visible right after edge N.
- Clear duration: the i_clear pulse is sampled at edge N.
  - o_busy=1 from after edge N to after edge N+DEPTH.
  - Zero-writes occur at edges N+1..N+DEPTH.
  - A read requested at edge N+DEPTH+1 sees zeros.
- i_clear and i_write_en in the same IDLE cycle: the write is performed, then the clear overwrites it.
- i_clear and i_read_en in the same IDLE cycle: the read is accepted and returns pre-clear data.
- Reset asserted mid-CLEAR: the clear aborts immediately.
  - o_busy=0 and FSM=IDLE.
  - The array is left partially cleared.
  - In-flight reads are discarded.

## Configuration
- SRAM_BYPASS_EN defined: write-first behaviour on a same-cycle, same-address read and write.
  - Returned word = i_data_in on bytes with i_byte_en=1, and the old mem contents on the other bytes.
- SRAM_BYPASS_EN undefined: read-first behaviour. The read returns the full pre-write word.

## Test plan
- Reset, then write 0x1122334455667788 with byte_en=0xFF to addr 5. Read addr 5 (READ_LATENCY=2) → valid exactly 2 edges after the request, with that data.
- Write 0xFF..FF to addr 3, then write 0x0 with byte_en=0x0F. Read addr 3 → 0xFFFFFFFF00000000.
- Same-cycle write of 0xAAAA... (byte_en=0xFF) and read of addr 7, whose old value is 0x1234 → 0xAAAA... with SRAM_BYPASS_EN, 0x1234 without it.
- Fill the array, then pulse i_clear.
  - o_busy stays high exactly DEPTH cycles.
  - A write and a read issued during busy produce no array change and no valid.
  - A post-clear read of every address returns 0.
- Reads every cycle to addrs 0,1,2,3 → four consecutive valid strobes in order. o_data_out holds addr 3's value afterwards.
- Assert i_nrst low at clr_addr=10 → outputs go to reset values asynchronously. Addr 0..9 read back 0, and addr 20 retains its pre-clear value.

Source files
------------

// File: rtl/sram_pipelined.sv
// 1W/1R on-chip buffer: per-byte write enables, READ_LATENCY-deep read pipeline, clear sequencer.
// Define SRAM_BYPASS_EN for write-first same-address behaviour; otherwise reads return the pre-write word.
module sram_pipelined #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_write_en,
  input  logic [ADDR_WIDTH-1:0]   i_write_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_in,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  input  logic                    i_read_en,
  input  logic [ADDR_WIDTH-1:0]   i_read_addr,
  input  logic                    i_clear,
  output logic [DATA_WIDTH-1:0]   o_data_out,
  output logic                    o_data_out_valid,
  output logic                    o_busy
);
  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_idle, w_wr_acc, w_rd_acc, w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data, w_rd_word;
  logic [NBYTES-1:0]     w_mem_be;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= S_IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      S_IDLE: begin
        if (i_clear) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        // i_clear is ignored here; the walk always runs to the last word
        if (&r_clr_addr) w_state_nxt = S_IDLE;
        else             w_clr_addr_nxt = r_clr_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idle   = (r_state == S_IDLE);
  assign o_busy   = ~w_idle;
  assign w_wr_acc = w_idle & i_write_en;
  assign w_rd_acc = w_idle & i_read_en;

  // The clear sequencer owns the single write port while busy
  assign w_mem_we   = w_wr_acc | ~w_idle;
  assign w_mem_addr = w_idle ? i_write_addr : r_clr_addr;
  assign w_mem_data = w_idle ? i_data_in    : '0;
  assign w_mem_be   = w_idle ? i_byte_en    : '1;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (w_mem_be[k]) r_mem[w_mem_addr][8*k +: 8] <= w_mem_data[8*k +: 8];
      end
    end
  end

`ifdef SRAM_BYPASS_EN
  always_comb begin
    w_rd_word = r_mem[i_read_addr];
    if (w_wr_acc && (i_write_addr == i_read_addr)) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_byte_en[k]) w_rd_word[8*k +: 8] = i_data_in[8*k +: 8];
      end
    end
  end
`else
  assign w_rd_word = r_mem[i_read_addr];
`endif

  // Stage 0 samples the array on the request edge; the last stage doubles as the output hold register
  genvar g;
  generate
    for (g = 0; g < READ_LATENCY; g++) begin : g_stage
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_vld;
      logic [DATA_WIDTH-1:0] w_in_data;
      logic                  w_in_vld;

      if (g == 0) begin : g_first
        assign w_in_data = w_rd_word;
        assign w_in_vld  = w_rd_acc;
      end else begin : g_next
        assign w_in_data = g_stage[g-1].r_data;
        assign w_in_vld  = g_stage[g-1].r_vld;
      end

      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_vld <= 1'b0;
        else         r_vld <= w_in_vld;
      end

      if (g == READ_LATENCY-1) begin : g_out
        always_ff @(posedge i_clk or negedge i_nrst) begin
          if (!i_nrst)       r_data <= '0;
          else if (w_in_vld) r_data <= w_in_data;
        end
      end else begin : g_mid
        always_ff @(posedge i_clk) begin
          r_data <= w_in_data;
        end
      end
    end
  endgenerate

  assign o_data_out       = g_stage[READ_LATENCY-1].r_data;
  assign o_data_out_valid = g_stage[READ_LATENCY-1].r_vld;

endmodule
